// File: rtl/spawn_pkg.sv
// spawn_pkg -- shared constants, types and helpers for the spawn picker.
//
// Contents:
//   GRID_ROWS / GRID_COLS / GRID_TILES  playfield geometry (15 x 20 = 300 tiles)
//   LFSR_SEED                           reset value of the candidate LFSR
//   row_t / col_t                       tile coordinates
//   spawn_state_t                       picker FSM states
//   lfsr_next                           one step of the x^16+x^14+x^13+x^11+1 LFSR
//   cand_row / cand_col                 map raw LFSR bits onto a legal tile

package spawn_pkg;

  localparam int unsigned GRID_ROWS  = 15;
  localparam int unsigned GRID_COLS  = 20;
  localparam int unsigned GRID_TILES = GRID_ROWS * GRID_COLS;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef logic [3:0] row_t;
  typedef logic [4:0] col_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } spawn_state_t;

  // Fibonacci form: stages 16,14,13,11 are bits 15,13,12,10; feedback enters
  // at bit 0. Maximal-length, so a nonzero seed never reaches zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Row nibble covers 0..15; the single out-of-range value folds to row 0.
  function automatic row_t cand_row(input logic [3:0] nib);
    return (nib == 4'd15) ? '0 : nib;
  endfunction

  // Column field covers 0..31; 20..31 fold down by one grid width.
  function automatic col_t cand_col(input logic [4:0] fld);
    return (fld >= 5'd20) ? fld - 5'd20 : fld;
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// spawn_lfsr -- free-running 16-bit Fibonacci LFSR supplying spawn candidates.
//
// Ports:
//   Clk      in   system clock
//   Reset_n  in   asynchronous active-low reset, reloads LFSR_SEED
//   lfsr     out  current LFSR state, advances on every rising edge

module spawn_lfsr
  import spawn_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  output logic [15:0] lfsr
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/spawn_picker.sv
// spawn_picker -- finds one free tile on the 15 x 20 playfield for a sprite spawn.
//
// On a request the blocking map (barrier code nonzero or tile occupied) is
// frozen into a snapshot and a pseudo-random start tile is taken from the
// LFSR. One snapshot tile is tested per cycle in row-major order with
// wrap-around; the first free tile is reported, or a failure after all 300
// tiles have been tested. The result is held until acknowledged.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Reset_n     in   asynchronous active-low reset
//   barrier     in   [0:14][0:19][0:1] level barrier codes, nonzero = blocked
//   occ_mask    in   [0:14][0:19] sprite occupancy, 1 = blocked
//   spawn_req   in   request, sampled only while idle
//   spawn_ack   in   result acknowledge, sampled only while a result is held
//   busy        out  search in progress
//   spawn_done  out  result valid, held until acknowledged
//   spawn_fail  out  qualifies spawn_done: no free tile exists
//   spawn_row   out  chosen row 0..14 (0 on failure)
//   spawn_col   out  chosen column 0..19 (0 on failure)
//
// Build option:
//   SPAWN_BORDER_EXCL_EN  when defined, rows 0, 1, 14 and columns 0, 19 are
//                         always treated as blocked in the snapshot.

module spawn_picker
  import spawn_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [0:14][0:19][0:1] barrier,
  input  logic [0:14][0:19]      occ_mask,
  input  logic                   spawn_req,
  input  logic                   spawn_ack,
  output logic                   busy,
  output logic                   spawn_done,
  output logic                   spawn_fail,
  output logic [3:0]             spawn_row,
  output logic [4:0]             spawn_col
);

  // --------------------------------------------------------------------------
  // Candidate source
  // --------------------------------------------------------------------------
  logic [15:0] lfsr;
  logic        lfsr_unused;

  spawn_lfsr u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .lfsr    (lfsr)
  );

  // Only the low nine bits select a candidate.
  assign lfsr_unused = ^lfsr[15:9];

  // --------------------------------------------------------------------------
  // Live blocking map, captured into the snapshot on the accepting edge
  // --------------------------------------------------------------------------
  logic [0:GRID_ROWS-1][0:GRID_COLS-1] snap_d;
  logic [0:GRID_ROWS-1][0:GRID_COLS-1] snap_q;

  for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
    for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
`ifdef SPAWN_BORDER_EXCL_EN
      localparam bit EDGE_TILE = (r < 2) || (r == GRID_ROWS - 1) ||
                                 (c == 0) || (c == GRID_COLS - 1);
      assign snap_d[r][c] = EDGE_TILE | (|barrier[r][c]) | occ_mask[r][c];
`else
      assign snap_d[r][c] = (|barrier[r][c]) | occ_mask[r][c];
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Scan state
  // --------------------------------------------------------------------------
  spawn_state_t state;
  spawn_state_t next_state;

  row_t       scan_row;
  col_t       scan_col;
  logic [8:0] check_cnt;
  logic       tile_free;
  logic       last_check;

  assign tile_free  = ~snap_q[scan_row][scan_col];
  // Tile being tested now is the 300th; if it is blocked the search fails.
  assign last_check = (check_cnt == 9'(GRID_TILES - 1));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (spawn_req) begin
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (tile_free || last_check) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (spawn_ack) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy       = (state == SCAN);
    spawn_done = (state == DONE);
  end

  // --------------------------------------------------------------------------
  // Snapshot, scan position, check counter and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      snap_q     <= '0;
      scan_row   <= '0;
      scan_col   <= '0;
      check_cnt  <= '0;
      spawn_fail <= 1'b0;
      spawn_row  <= '0;
      spawn_col  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (spawn_req) begin
            snap_q    <= snap_d;
            scan_row  <= cand_row(lfsr[3:0]);
            scan_col  <= cand_col(lfsr[8:4]);
            check_cnt <= '0;
          end
        end
        SCAN: begin
          if (tile_free) begin
            spawn_row  <= scan_row;
            spawn_col  <= scan_col;
            spawn_fail <= 1'b0;
          end else begin
            check_cnt <= check_cnt + 9'd1;
            if (scan_col == col_t'(GRID_COLS - 1)) begin
              scan_col <= '0;
              scan_row <= (scan_row == row_t'(GRID_ROWS - 1)) ? '0 : scan_row + 4'd1;
            end else begin
              scan_col <= scan_col + 5'd1;
            end
            if (last_check) begin
              spawn_fail <= 1'b1;
              spawn_row  <= '0;
              spawn_col  <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spawn_picker.sv
// tb_spawn_picker -- scoreboard bench for spawn_picker.
//
// The stimulus process predicts each accepted request from a tile-index model
// of the search (linear index, modulo-300 walk) and queues the expectation;
// the monitor pops it when spawn_done rises and checks result, latency and
// busy duration. Latency is counted with the accepting cycle as cycle 1.

module tb_spawn_picker;

  localparam int ROWS  = 15;
  localparam int COLS  = 20;
  localparam int TILES = 300;

  logic                   Clk;
  logic                   Reset_n;
  logic [0:14][0:19][0:1] barrier;
  logic [0:14][0:19]      occ_mask;
  logic                   spawn_req;
  logic                   spawn_ack;
  logic                   busy;
  logic                   spawn_done;
  logic                   spawn_fail;
  logic [3:0]             spawn_row;
  logic [4:0]             spawn_col;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] lfsr_m;

  typedef struct {
    bit fail;
    int row;
    int col;
    int checks;
    int acc;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  bit   done_prev = 1'b0;
  int   busy_cnt  = 0;

  spawn_picker dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .barrier    (barrier),
    .occ_mask   (occ_mask),
    .spawn_req  (spawn_req),
    .spawn_ack  (spawn_ack),
    .busy       (busy),
    .spawn_done (spawn_done),
    .spawn_fail (spawn_fail),
    .spawn_row  (spawn_row),
    .spawn_col  (spawn_col)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Reference LFSR: feedback is the parity of taps 16,14,13,11 (mask B400).
  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) lfsr_m <= 16'hACE1;
    else          lfsr_m <= step(lfsr_m);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void cand_pos(input logic [15:0] l, output int r, output int c);
    r = int'(l[3:0]);
    if (r == 15) r = 0;
    c = int'(l[8:4]);
    if (c >= 20) c = c - 20;
  endfunction

  function automatic exp_t predict(input logic [15:0] l, input int acc);
    bit   blk [TILES];
    int   r0, c0, start, t;
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        blk[r*COLS + c] = (barrier[r][c] != 2'b00) || occ_mask[r][c];
`ifdef SPAWN_BORDER_EXCL_EN
        if (r < 2 || r == 14 || c == 0 || c == 19) blk[r*COLS + c] = 1'b1;
`endif
      end
    end
    cand_pos(l, r0, c0);
    start    = r0*COLS + c0;
    e.fail   = 1'b1;
    e.row    = 0;
    e.col    = 0;
    e.checks = TILES;
    e.acc    = acc;
    for (int i = 0; i < TILES; i++) begin
      t = (start + i) % TILES;
      if (!blk[t]) begin
        e.fail   = 1'b0;
        e.row    = t / COLS;
        e.col    = t % COLS;
        e.checks = i + 1;
        break;
      end
    end
    return e;
  endfunction

  // Monitor: compares every presented result against the queued prediction.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      done_prev = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (busy) busy_cnt++;
      if (spawn_done && !done_prev) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          cur_exp = q.pop_front();
          chk("fail_flag",   int'(spawn_fail), int'(cur_exp.fail));
          chk("row",         int'(spawn_row),  cur_exp.row);
          chk("col",         int'(spawn_col),  cur_exp.col);
          chk("latency",     cyc - cur_exp.acc + 1, cur_exp.checks + 1);
          chk("busy_cycles", busy_cnt, cur_exp.checks);
        end
        busy_cnt = 0;
      end else if (spawn_done) begin
        chk("row_hold", int'(spawn_row), cur_exp.row);
        chk("col_hold", int'(spawn_col), cur_exp.col);
      end
      done_prev = spawn_done;
    end
  end

  task automatic clear_maps();
    barrier  = '0;
    occ_mask = '0;
  endtask

  task automatic set_tile(input int t);
    if ($urandom_range(0, 1) == 1) barrier[t / COLS][t % COLS] = 2'($urandom_range(1, 3));
    else                           occ_mask[t / COLS][t % COLS] = 1'b1;
  endtask

  // mode 0 clear, 1 sparse, 2 dense, 3 one free tile, 4 all blocked
  task automatic fill_maps(input int mode);
    clear_maps();
    for (int t = 0; t < TILES; t++) begin
      case (mode)
        1:       if ($urandom_range(0, 9) == 0) set_tile(t);
        2:       if ($urandom_range(0, 9) != 0) set_tile(t);
        3, 4:    set_tile(t);
        default: ;
      endcase
    end
    if (mode == 3) begin
      int t;
      t = $urandom_range(0, TILES - 1);
      barrier[t / COLS][t % COLS] = 2'b00;
      occ_mask[t / COLS][t % COLS] = 1'b0;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after accept.
  task automatic issue();
    q.push_back(predict(lfsr_m, cyc + 1));
    spawn_req = 1'b1;
    @(negedge Clk);
    spawn_req = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (spawn_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic finish_txn(input int hold, input bit chain);
    bit ok;
    wait_done(ok);
    repeat (hold) @(negedge Clk);
    spawn_ack = 1'b1;
    if (chain) spawn_req = 1'b1;
    @(negedge Clk);
    spawn_ack = 1'b0;
    chk("done_drop_on_ack", int'(spawn_done), 0);
    if (chain) begin
      q.push_back(predict(lfsr_m, cyc + 1));
      @(negedge Clk);
      spawn_req = 1'b0;
    end
  endtask

  task automatic wait_cand(input int r, input int c, output bit ok);
    int rr, cc;
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      cand_pos(lfsr_m, rr, cc);
      if (rr == r && cc == c) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) chk("cand_wait_timeout", 0, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int s0, r0, c0;
    Reset_n   = 1'b0;
    spawn_req = 1'b0;
    spawn_ack = 1'b0;
    clear_maps();
    repeat (3) @(negedge Clk);
    chk("rst_busy", int'(busy),       0);
    chk("rst_done", int'(spawn_done), 0);
    chk("rst_fail", int'(spawn_fail), 0);
    chk("rst_row",  int'(spawn_row),  0);
    chk("rst_col",  int'(spawn_col),  0);
    #2 Reset_n = 1'b1;

    // Empty map, request one cycle after reset release.
    @(negedge Clk);
    issue();
    finish_txn(1, 1'b0);

    // Candidate (3,5) blocked, (3,6) free.
    clear_maps();
    wait_cand(3, 5, ok);
    if (ok) begin
      set_tile(3*COLS + 5);
      issue();
      finish_txn(0, 1'b0);
    end

    // Candidate (14,19) blocked: search wraps to (0,0).
    clear_maps();
    wait_cand(14, 19, ok);
    if (ok) begin
      set_tile(14*COLS + 19);
      issue();
      finish_txn(0, 1'b0);
    end

    // Random maps of varying density.
    for (int n = 0; n < 12; n++) begin
      fill_maps($urandom_range(0, 3));
      issue();
      finish_txn($urandom_range(0, 3), 1'b0);
    end

    // Request held through the acknowledge cycle: accepted one cycle later.
    fill_maps(1);
    issue();
    finish_txn(1, 1'b1);
    finish_txn(0, 1'b0);

    // Everything blocked: failure after 300 checks.
    fill_maps(4);
    issue();
    finish_txn(2, 1'b0);

    // Map changes after accept must not disturb the search; extra request
    // during the scan must be ignored.
    clear_maps();
    cand_pos(lfsr_m, r0, c0);
    s0 = r0*COLS + c0;
    for (int k = 0; k < 5; k++) set_tile((s0 + k) % TILES);
    issue();
    barrier   = '1;
    occ_mask  = '1;
    spawn_req = 1'b1;
    @(negedge Clk);
    spawn_req = 1'b0;
    finish_txn(0, 1'b0);
    repeat (10) @(negedge Clk);
    chk("no_second_done", int'(spawn_done), 0);
    clear_maps();

    // Only (0,0) free: found normally, failure when the border is excluded.
    barrier       = '1;
    barrier[0][0] = 2'b00;
    issue();
    finish_txn(0, 1'b0);
    clear_maps();

    // Reset in the middle of a scan abandons the request.
    fill_maps(4);
    issue();
    repeat (50) @(negedge Clk);
    chk("busy_mid_scan", int'(busy), 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy),       0);
    chk("midrst_done", int'(spawn_done), 0);
    chk("midrst_fail", int'(spawn_fail), 0);
    chk("midrst_row",  int'(spawn_row),  0);
    chk("midrst_col",  int'(spawn_col),  0);
    q.delete();
    @(negedge Clk);
    #2 Reset_n = 1'b1;
    repeat (10) @(negedge Clk);
    chk("done_after_reset", int'(spawn_done), 0);
    chk("busy_after_reset", int'(busy),       0);
    clear_maps();
    issue();
    finish_txn(0, 1'b0);

    repeat (5) @(negedge Clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
